lsu_mem_sequencer: RTL and testbench
====================================

Name: lsu_mem_sequencer

Overview:
- Sits directly downstream of the address generation stage inside the LSU.
- Accepts one warp-wide memory operation: 8 per-thread addresses, 8 per-thread store values, an active-thread mask and a load/store op.
- Serialises the operation into single-word requests on the data-memory port, one outstanding request at a time.
- Collects load data into per-thread result registers and signals completion to the core.

Parameters:
- DATA_WIDTH, 16, width of data words and store/load values
- ADDR_WIDTH, 8, width of memory addresses
- NUM_THREADS, 8, threads per warp; thread index width is $clog2(NUM_THREADS)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  warp operation presented
- op_ready  out  1  block can accept an operation
- op_is_store  in  1  1 = store, 0 = load
- op_mask  in  NUM_THREADS  active-thread mask, bit i = thread i
- op_addr  in  ADDR_WIDTH x NUM_THREADS  per-thread addresses from AGU
- op_wdata  in  DATA_WIDTH x NUM_THREADS  per-thread store data
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_WIDTH  request address
- mem_wdata  out  DATA_WIDTH  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data returned this cycle
- mem_rdata  in  DATA_WIDTH  read data
- ld_data  out  DATA_WIDTH x NUM_THREADS  per-thread load results
- done  out  1  one-cycle pulse: operation complete
- busy  out  1  operation in progress (state != IDLE)

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE.
  - op_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; done=0; busy=0.
  - All ld_data = 0; captured registers and thread index = 0.
- Reset asserted mid-operation aborts immediately. Any in-flight mem_rvalid arriving after release is ignored, because the block is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - op_ready=1.
  - On op_valid & op_ready: capture op_is_store, op_mask, op_addr, op_wdata.
  - If op_mask==0, go to DONE. Otherwise set idx = lowest set mask bit and go to ISSUE.
  - Loads do not clear ld_data. Bits for inactive threads keep their previous values.
- ISSUE:
  - mem_req=1, mem_we=op_is_store, mem_addr=addr[idx], mem_wdata=wdata[idx].
  - Outputs are registered-stable while waiting: they hold until mem_gnt.
  - On mem_gnt, store: advance idx to the next set mask bit above idx. If there is none, go to DONE; otherwise stay in ISSUE.
  - On mem_gnt, load: go to WAIT with mem_req=0.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: ld_data[idx] <= mem_rdata, then advance idx exactly as for a store.
  - mem_rvalid in any other state is ignored.
- Load merge: if the next active thread's address equals the address just loaded, copy that data into it in the same cycle without issuing a request. This repeats over consecutive equal addresses, so e.g. broadcast addresses complete after one memory access. Stores never merge.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - op_ready=0 in DONE.
  - ld_data holds until overwritten by a later load.
- op_ready=0 in ISSUE, WAIT and DONE; op_valid there is ignored, with no capture.
- Latency with mem_gnt tied high, all 8 threads active, distinct addresses (accept edge = cycle 0):
  - Store: ISSUE cycles 1-8, done in cycle 9.
  - Load with rvalid one cycle after gnt: 16 cycles of ISSUE/WAIT, done in cycle 17.
- Thread order is strictly ascending index. No reordering.

Decomposition:
- Shared package lsu_pkg:
  - DATA_WIDTH, ADDR_WIDTH, NUM_THREADS constants.
  - State enum typedef (IDLE, ISSUE, WAIT, DONE).
  - Thread-index typedef.
- Sub-module mask_next_idx (combinational): given the mask and current idx, returns the next set bit above idx plus a none flag. It is also used for the initial lowest-set-bit search, with "idx = -1" semantics via a start flag.

Test Plan:
- Store, mask=8'hFF, addr[i]=8'h10+i, wdata[i]=16'hA000+i, gnt tied 1 -> 8 writes in ascending order at 0x10..0x17 with matching data; done pulse in cycle 9; op_ready low throughout.
- Load, mask=8'b1010_0101, addr[i]=8'h20+i, memory returns 16'hB000+addr one cycle after gnt -> requests only to 0x20,0x22,0x25,0x27; ld_data[0,2,5,7]=B020,B022,B025,B027; other ld_data unchanged.
- Load, mask=8'hFF, all addr=8'h30, rdata=16'h1234 -> exactly one mem_req; all ld_data=16'h1234; done 3 cycles after accept.
- mem_gnt held low 5 cycles in ISSUE -> mem_req, mem_addr and mem_wdata stable for those cycles; the sequence then proceeds normally.
- op_mask=0 -> no mem_req; done asserted in the cycle after accept; op_valid during DONE is not accepted.
- reset pulled low during WAIT of thread 3 -> all outputs at reset values immediately; a late mem_rvalid after release leaves ld_data=0; a new op is accepted normally.

Source files
------------

// File: rtl/lsu_mem_sequencer_pkg.sv
// lsu_pkg: shared constants, FSM state and thread-index types for the LSU memory sequencer
// Ports: none (package)
package lsu_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 8;
    localparam int NUM_THREADS = 8;
    localparam int IDX_WIDTH   = $clog2(NUM_THREADS);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    typedef logic [IDX_WIDTH-1:0] idx_t;
endpackage

// File: rtl/lsu_mem_sequencer_mask_next_idx.sv
// mask_next_idx: finds the lowest set mask bit above idx (or the lowest set bit overall when start is high)
// Ports: mask - thread mask; idx - current thread; start - search from bit 0;
//        next_idx - found thread; none - no qualifying bit
module mask_next_idx
    import lsu_pkg::*;
#(
    parameter int NUM_THREADS = lsu_pkg::NUM_THREADS
) (
    input  logic [NUM_THREADS-1:0]         mask,
    input  logic [$clog2(NUM_THREADS)-1:0] idx,
    input  logic                           start,
    output logic [$clog2(NUM_THREADS)-1:0] next_idx,
    output logic                           none
);
    localparam int IW = $clog2(NUM_THREADS);
    always_comb begin
        next_idx = '0;
        none = 1'b1;
        for (int j = NUM_THREADS - 1; j >= 0; j--)
            if (mask[j] && (start || j > int'(idx))) begin
                next_idx = IW'(j);
                none = 1'b0;
            end
    end
endmodule

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: serialises a warp-wide load/store into single-word memory requests
// Ports: clk, reset (async, active-low);
//        op_valid/op_ready/op_is_store/op_mask/op_addr/op_wdata - warp operation from the AGU;
//        mem_req/mem_we/mem_addr/mem_wdata/mem_gnt/mem_rvalid/mem_rdata - data-memory port;
//        ld_data - per-thread load results; done - completion pulse; busy - operation in progress
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH  = lsu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = lsu_pkg::ADDR_WIDTH,
    parameter int NUM_THREADS = lsu_pkg::NUM_THREADS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              op_valid,
    output logic                              op_ready,
    input  logic                              op_is_store,
    input  logic [NUM_THREADS-1:0]            op_mask,
    input  logic [NUM_THREADS*ADDR_WIDTH-1:0] op_addr,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] op_wdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_gnt,
    input  logic                              mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] ld_data,
    output logic                              done,
    output logic                              busy
);
    localparam int IW = $clog2(NUM_THREADS);
    state_e                            state;
    logic                              st_r;
    logic [NUM_THREADS-1:0]            mask_r;
    logic [NUM_THREADS*ADDR_WIDTH-1:0] addr_r;
    logic [NUM_THREADS*DATA_WIDTH-1:0] wdata_r;
    logic [IW-1:0]                     idx;
    logic [NUM_THREADS-1:0]            merge;
    logic                              chain;
    logic [NUM_THREADS-1:0]            search_mask;
    logic [IW-1:0]                     nxt;
    logic                              none;
    logic [ADDR_WIDTH-1:0]             cur_addr;
    assign cur_addr = addr_r[idx*ADDR_WIDTH +: ADDR_WIDTH];
    // Threads directly following idx that load the same address share the returned word.
    always_comb begin
        merge = '0;
        chain = 1'b1;
        for (int j = 0; j < NUM_THREADS; j++)
            if (!st_r && j > int'(idx) && mask_r[j] && chain) begin
                if (addr_r[j*ADDR_WIDTH +: ADDR_WIDTH] == cur_addr) merge[j] = 1'b1;
                else chain = 1'b0;
            end
    end
    assign search_mask = (state == IDLE) ? op_mask : (mask_r & ~merge);
    mask_next_idx #(.NUM_THREADS(NUM_THREADS)) u_next (
        .mask    (search_mask),
        .idx     (idx),
        .start   (state == IDLE),
        .next_idx(nxt),
        .none    (none)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            st_r    <= 1'b0;
            mask_r  <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            idx     <= '0;
            ld_data <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    st_r    <= op_is_store;
                    mask_r  <= op_mask;
                    addr_r  <= op_addr;
                    wdata_r <= op_wdata;
                    idx     <= nxt;
                    state   <= none ? DONE : ISSUE;
                end
                ISSUE: if (mem_gnt) begin
                    if (st_r) begin
                        idx   <= nxt;
                        state <= none ? DONE : ISSUE;
                    end else state <= WAIT;
                end
                WAIT: if (mem_rvalid) begin
                    for (int j = 0; j < NUM_THREADS; j++)
                        if (j == int'(idx) || merge[j]) ld_data[j*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                    idx   <= nxt;
                    state <= none ? DONE : ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign op_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign mem_req   = state == ISSUE;
    assign mem_we    = mem_req & st_r;
    assign mem_addr  = mem_req ? cur_addr : '0;
    assign mem_wdata = mem_req ? wdata_r[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb_lsu_mem_sequencer: directed self-checking bench for lsu_mem_sequencer
module tb_lsu_mem_sequencer;
    logic         clk;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic         op_is_store;
    logic [7:0]   op_mask;
    logic [63:0]  op_addr;
    logic [127:0] op_wdata;
    logic         mem_req;
    logic         mem_we;
    logic [7:0]   mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [15:0]  mem_rdata;
    logic [127:0] ld_data;
    logic         done;
    logic         busy;

    lsu_mem_sequencer dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
        .op_mask(op_mask), .op_addr(op_addr), .op_wdata(op_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ld_data(ld_data), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          nreq;
    int          done_cyc;
    int          done_cnt;
    int          rdy_bad;
    logic [7:0]  raddr [16];
    logic [15:0] rdat  [16];
    logic        rwe   [16];
    logic        pend;
    logic [7:0]  paddr;
    logic        use_fixed;
    logic [15:0] fixed_rdata;
    logic [127:0] exp_ld;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, then drive the memory response after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (mem_req && mem_gnt) begin
            if (nreq < 16) begin
                raddr[nreq] = mem_addr;
                rdat[nreq]  = mem_wdata;
                rwe[nreq]   = mem_we;
            end
            nreq++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (op_ready && (busy || done || mem_req)) rdy_bad++;
        pend  = mem_req && mem_gnt && !mem_we;
        paddr = mem_addr;
        @(posedge clk);
        #1;
        cyc++;
        mem_rvalid = pend;
        mem_rdata  = use_fixed ? fixed_rdata : 16'hB000 + {8'h00, paddr};
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic start_op(input logic st, input logic [7:0] m);
        op_is_store = st;
        op_mask     = m;
        op_valid    = 1'b1;
        nreq        = 0;
        done_cnt    = 0;
        done_cyc    = -1;
        rdy_bad     = 0;
        tick();
        op_valid = 1'b0;
        cyc      = 1;
    endtask

    initial begin
        reset = 1'b0;
        op_valid = 1'b0; op_is_store = 1'b0; op_mask = '0; op_addr = '0; op_wdata = '0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        use_fixed = 1'b0; fixed_rdata = '0; pend = 1'b0; paddr = '0;
        cyc = 0; nreq = 0; done_cyc = -1; done_cnt = 0; rdy_bad = 0;
        #2;
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ld_data", ld_data, 128'h0);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;

        // Full-warp store, grant always high
        for (int i = 0; i < 8; i++) begin
            op_addr[i*8 +: 8]    = 8'(8'h10 + i);
            op_wdata[i*16 +: 16] = 16'(16'hA000 + i);
        end
        start_op(1'b1, 8'hFF);
        run(12);
        chk("st_nreq", nreq, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("st_addr%0d", i), raddr[i], 8'(8'h10 + i));
            chk($sformatf("st_data%0d", i), rdat[i], 16'(16'hA000 + i));
            chk($sformatf("st_we%0d", i), rwe[i], 1'b1);
        end
        chk("st_done_cyc", done_cyc, 9);
        chk("st_done_cnt", done_cnt, 1);
        chk("st_ready_low", rdy_bad, 0);
        chk("st_ld_untouched", ld_data, 128'h0);

        // Broadcast load: one access fills every thread
        for (int i = 0; i < 8; i++) op_addr[i*8 +: 8] = 8'h30;
        use_fixed = 1'b1; fixed_rdata = 16'h1234;
        start_op(1'b0, 8'hFF);
        run(6);
        use_fixed = 1'b0;
        chk("bc_nreq", nreq, 1);
        chk("bc_addr", raddr[0], 8'h30);
        chk("bc_we", rwe[0], 1'b0);
        chk("bc_done_cyc", done_cyc, 3);
        chk("bc_ld", ld_data, {8{16'h1234}});

        // Sparse load: only masked threads are requested and written
        for (int i = 0; i < 8; i++) op_addr[i*8 +: 8] = 8'(8'h20 + i);
        start_op(1'b0, 8'b1010_0101);
        run(12);
        chk("sp_nreq", nreq, 4);
        chk("sp_addr0", raddr[0], 8'h20);
        chk("sp_addr1", raddr[1], 8'h22);
        chk("sp_addr2", raddr[2], 8'h25);
        chk("sp_addr3", raddr[3], 8'h27);
        chk("sp_done_cyc", done_cyc, 9);
        exp_ld = {16'hB027, 16'h1234, 16'hB025, 16'h1234, 16'h1234, 16'hB022, 16'h1234, 16'hB020};
        chk("sp_ld", ld_data, exp_ld);

        // Grant withheld for five cycles: request must hold steady
        for (int i = 0; i < 8; i++) begin
            op_addr[i*8 +: 8]    = 8'(8'h40 + i);
            op_wdata[i*16 +: 16] = 16'(16'hC000 + i);
        end
        mem_gnt = 1'b0;
        start_op(1'b1, 8'b0000_0110);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_req%0d", k), mem_req, 1'b1);
            chk($sformatf("stall_addr%0d", k), mem_addr, 8'h41);
            chk($sformatf("stall_wdata%0d", k), mem_wdata, 16'hC001);
            if (k < 4) tick();
        end
        tick();
        mem_gnt = 1'b1;
        run(5);
        chk("stall_nreq", nreq, 2);
        chk("stall_a0", raddr[0], 8'h41);
        chk("stall_d0", rdat[0], 16'hC001);
        chk("stall_a1", raddr[1], 8'h42);
        chk("stall_d1", rdat[1], 16'hC002);
        chk("stall_done_cyc", done_cyc, 8);

        // Empty mask: straight to done; an op offered during done is ignored
        start_op(1'b0, 8'h00);
        chk("m0_done", done, 1'b1);
        chk("m0_req", mem_req, 1'b0);
        op_is_store = 1'b1;
        op_mask = 8'hFF;
        op_valid = 1'b1;
        chk("m0_ready_in_done", op_ready, 1'b0);
        tick();
        op_valid = 1'b0;
        chk("m0_not_accepted", busy, 1'b0);
        run(3);
        chk("m0_nreq", nreq, 0);
        chk("m0_done_cnt", done_cnt, 1);

        // Reset during the WAIT of thread 3
        for (int i = 0; i < 8; i++) op_addr[i*8 +: 8] = 8'(8'h50 + i);
        start_op(1'b0, 8'hFF);
        run(7);
        chk("rw_in_wait", {mem_req, busy, mem_rvalid}, 3'b011);
        reset = 1'b0;
        #1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_ready", op_ready, 1'b1);
        chk("rw_req", mem_req, 1'b0);
        chk("rw_ld", ld_data, 128'h0);
        #2 reset = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        pend = 1'b0;
        chk("rw_late_rvalid", ld_data, 128'h0);
        chk("rw_idle", busy, 1'b0);
        op_addr[7:0]   = 8'h60;
        op_wdata[15:0] = 16'h5555;
        start_op(1'b1, 8'h01);
        run(4);
        chk("rw_new_nreq", nreq, 1);
        chk("rw_new_addr", raddr[0], 8'h60);
        chk("rw_new_data", rdat[0], 16'h5555);
        chk("rw_new_we", rwe[0], 1'b1);
        chk("rw_new_done_cyc", done_cyc, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
